// File: rtl/i2c_slave_if.sv
// Register-file side of the I2C responder: pointer, write strobe/data, read request/data, status.
// slave = the I2C responder's view; master = the SoC register file that answers it.
interface i2c_slave_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       nack_seen;

    modport slave  (output reg_addr, reg_wdata, reg_wr, reg_rd, busy, nack_seen, input reg_rdata);
    modport master (input reg_addr, reg_wdata, reg_wr, reg_rd, busy, nack_seen, output reg_rdata);
endinterface

// File: rtl/i2c_slave.sv
// I2C responder with subaddress pointer; writes strobe one cycle after the 8th SCL rise, reads fetch at ACK fall.
// No clock stretching: the register file must answer reg_rd on the next cycle; SDA is open drain (0 or Z).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FREQ       = 50
) (
    input  logic       sys_clock,
    input  logic       reset,
    inout  wire        SDA,
    input  logic       SCL,
    i2c_slave_if.slave regs
);
    localparam int T_HOLD = (FREQ >> 2) + 1;
    localparam int HW     = $clog2(T_HOLD + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sda_sync, scl_sync;
    logic [3:0]    sda_win, scl_win;
    logic          sda_f, scl_f, sda_f_d, scl_f_d;
    logic          start_det, stop_det, scl_rise, scl_fall;
    logic [6:0]    rx_sh;
    logic [7:0]    rx_byte, tx_sh;
    logic [3:0]    bit_cnt;
    logic          counting, last_bit, addr_hit, ack_on, rw_q, want_low;
    logic [HW-1:0] hold_cnt;
    logic          sda_oe;
    logic [7:0]    addr_q, wdata_q;
    logic          wr_q, rd_q, rd_d, busy_q, nack_q;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // Filtered level only moves once four consecutive synchronised samples agree.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            sda_sync <= 2'b11;
            scl_sync <= 2'b11;
            sda_win  <= 4'hF;
            scl_win  <= 4'hF;
            sda_f    <= 1'b1;
            scl_f    <= 1'b1;
            sda_f_d  <= 1'b1;
            scl_f_d  <= 1'b1;
        end else begin
            sda_sync <= {sda_sync[0], SDA};
            scl_sync <= {scl_sync[0], SCL};
            sda_win  <= {sda_win[2:0], sda_sync[1]};
            scl_win  <= {scl_win[2:0], scl_sync[1]};
            if (&sda_win) sda_f <= 1'b1;
            else if (~|sda_win) sda_f <= 1'b0;
            if (&scl_win) scl_f <= 1'b1;
            else if (~|scl_win) scl_f <= 1'b0;
            sda_f_d  <= sda_f;
            scl_f_d  <= scl_f;
        end
    end

    assign start_det = scl_f & sda_f_d & ~sda_f;
    assign stop_det  = scl_f & ~sda_f_d & sda_f;
    assign scl_rise  = scl_f & ~scl_f_d;
    assign scl_fall  = ~scl_f & scl_f_d;
    assign rx_byte   = {rx_sh, sda_f};
    assign last_bit  = scl_rise && (bit_cnt == 4'd7);
    assign addr_hit  = (rx_byte[7:1] == SLAVE_ADDR);
    assign counting  = (state_q == S_ADDR) || (state_q == S_SUB) ||
                       (state_q == S_WDATA) || (state_q == S_RDATA);

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        want_low = 1'b0;
        if (stop_det) begin
            state_d = S_IDLE;
        end else if (start_det) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR:      if (last_bit) state_d = addr_hit ? S_ADDR_ACK : S_WAIT;
                S_ADDR_ACK:  if (scl_fall && ack_on) state_d = rw_q ? S_RDATA : S_SUB;
                S_SUB:       if (last_bit) state_d = S_SUB_ACK;
                S_SUB_ACK:   if (scl_fall && ack_on) state_d = S_WDATA;
                S_WDATA:     if (last_bit) state_d = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall && ack_on) state_d = S_WDATA;
                S_RDATA:     if (scl_fall && (bit_cnt == 4'd8)) state_d = S_RDATA_ACK;
                S_RDATA_ACK: begin
                    if (scl_rise && sda_f) state_d = S_WAIT;
                    else if (scl_fall)     state_d = S_RDATA;
                end
                default: ;
            endcase
        end
        // Sampled only when the hold timer expires, i.e. well inside SCL low.
        case (state_q)
            S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: want_low = ack_on;
            S_RDATA:                            want_low = ~tx_sh[7];
            default:                            want_low = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            rx_sh    <= '0;
            tx_sh    <= '0;
            bit_cnt  <= '0;
            ack_on   <= 1'b0;
            rw_q     <= 1'b0;
            hold_cnt <= '0;
            sda_oe   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd_d     <= 1'b0;
            busy_q   <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            rd_d <= rd_q;
            if (rd_d) tx_sh <= regs.reg_rdata;
            if (wr_q) addr_q <= addr_q + 8'd1;
            if (scl_rise) rx_sh <= rx_byte[6:0];

            if (start_det || (state_d != state_q)) begin
                bit_cnt <= '0;
                ack_on  <= 1'b0;
            end else begin
                if (scl_rise && counting) bit_cnt <= bit_cnt + 4'd1;
                if (scl_fall) ack_on <= 1'b1;
            end

            if (start_det || stop_det) begin
                sda_oe   <= 1'b0;
                hold_cnt <= '0;
                if (stop_det) busy_q <= 1'b0;
            end else begin
                if (scl_fall)              hold_cnt <= HW'(T_HOLD);
                else if (hold_cnt != '0)   hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1))    sda_oe   <= want_low;
                case (state_q)
                    S_ADDR: if (last_bit) begin
                        rw_q   <= rx_byte[0];
                        busy_q <= addr_hit;
                        if (addr_hit) nack_q <= 1'b0;
                    end
                    S_ADDR_ACK: if (scl_fall && ack_on && rw_q) rd_q <= 1'b1;
                    S_SUB:      if (last_bit) addr_q <= rx_byte;
                    S_WDATA: if (last_bit) begin
                        wdata_q <= rx_byte;
                        wr_q    <= 1'b1;
                    end
                    S_RDATA: if (scl_fall && (bit_cnt != 4'd8)) tx_sh <= {tx_sh[6:0], 1'b0};
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) nack_q <= 1'b1;
                            else       addr_q <= addr_q + 8'd1;
                        end else if (scl_fall) begin
                            rd_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign regs.reg_addr  = addr_q;
    assign regs.reg_wdata = wdata_q;
    assign regs.reg_wr    = wr_q;
    assign regs.reg_rd    = rd_q;
    assign regs.busy      = busy_q;
    assign regs.nack_seen = nack_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level I2C master driving i2c_slave; transaction-level model of register memory and pointer.
module tb_i2c_slave;
    localparam logic [6:0] SLV = 7'h50;
    localparam int         Q   = 24;

    logic sys_clock = 1'b0;
    logic reset     = 1'b1;
    logic scl       = 1'b1;
    logic m_low     = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_if rif ();
    logic [7:0] mem [256];
    assign rif.reg_rdata = mem[rif.reg_addr];

    i2c_slave #(.SLAVE_ADDR(SLV), .FREQ(50)) dut (
        .sys_clock(sys_clock),
        .reset    (reset),
        .SDA      (sda),
        .SCL      (scl),
        .regs     (rif)
    );

    always #5 sys_clock = ~sys_clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] wr_seen[$], wr_exp[$];
    logic [7:0]  rd_seen[$], rd_exp[$];
    logic [7:0]  exp_mem [256];
    logic [7:0]  exp_ptr = 8'h00;
    logic [7:0]  dbuf [4];

    // Register-file side: backs the read port and records strobes.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(negedge sys_clock);
            if (rif.reg_wr) begin
                wr_seen.push_back({rif.reg_addr, rif.reg_wdata});
                mem[rif.reg_addr] = rif.reg_wdata;
            end
            if (rif.reg_rd) rd_seen.push_back(rif.reg_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge sys_clock);
        #1;
    endtask

    // One SCL period; b=1 releases SDA. Returns SDA sampled mid-high.
    task automatic put_bit(input logic b, output logic s);
        wait_q(); m_low = ~b;
        wait_q(); scl = 1'b1;
        wait_q(); s = sda;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q(); m_low = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q(); m_low = 1'b1;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); m_low = 1'b1;
        wait_q(); scl = 1'b1;
        wait_q(); m_low = 1'b0;
        wait_q();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) put_bit(b[i], s);
        put_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, s);
            b[i] = s;
        end
        put_bit(~ack, s);
    endtask

    task automatic do_write(input logic [6:0] a7, input logic [7:0] sub, input int n, input logic stop_after);
        logic ack, hit;
        hit = (a7 == SLV);
        i2c_start();
        wr_byte({a7, 1'b0}, ack);
        check("addr_ack", 32'(ack), 32'(hit));
        check("busy_after_addr", 32'(rif.busy), 32'(hit));
        wr_byte(sub, ack);
        check("sub_ack", 32'(ack), 32'(hit));
        for (int k = 0; k < n; k++) begin
            wr_byte(dbuf[k], ack);
            check("data_ack", 32'(ack), 32'(hit));
        end
        if (stop_after) begin
            i2c_stop();
            check("busy_after_stop", 32'(rif.busy), 32'(0));
        end
        if (hit) begin
            exp_ptr = sub;
            for (int k = 0; k < n; k++) begin
                wr_exp.push_back({exp_ptr, dbuf[k]});
                exp_mem[exp_ptr] = dbuf[k];
                exp_ptr++;
            end
        end
    endtask

    // Reads n bytes from the current pointer, NACKing the last one.
    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        wr_byte({SLV, 1'b1}, ack);
        check("raddr_ack", 32'(ack), 32'(1));
        for (int k = 0; k < n; k++) begin
            rd_byte(k != n - 1, b);
            check("rdata", 32'(b), 32'(exp_mem[exp_ptr]));
            rd_exp.push_back(exp_ptr);
            if (k != n - 1) exp_ptr++;
        end
        i2c_stop();
        check("nack_seen", 32'(rif.nack_seen), 32'(1));
    endtask

    task automatic flush_checks(input string tag);
        check({tag, "_wr_count"}, 32'(wr_seen.size()), 32'(wr_exp.size()));
        while (wr_seen.size() > 0 && wr_exp.size() > 0)
            check({tag, "_wr"}, 32'(wr_seen.pop_front()), 32'(wr_exp.pop_front()));
        check({tag, "_rd_count"}, 32'(rd_seen.size()), 32'(rd_exp.size()));
        while (rd_seen.size() > 0 && rd_exp.size() > 0)
            check({tag, "_rd"}, 32'(rd_seen.pop_front()), 32'(rd_exp.pop_front()));
        wr_seen.delete(); wr_exp.delete(); rd_seen.delete(); rd_exp.delete();
        check({tag, "_reg_addr"}, 32'(rif.reg_addr), 32'(exp_ptr));
    endtask

    initial begin
        logic       s, ack;
        int         op, n;
        logic [6:0] a7;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;

        repeat (5) @(negedge sys_clock);
        check("rst_busy", 32'(rif.busy), 32'(0));
        check("rst_reg_addr", 32'(rif.reg_addr), 32'(0));
        check("rst_reg_wr", 32'(rif.reg_wr), 32'(0));
        check("rst_reg_rd", 32'(rif.reg_rd), 32'(0));
        check("rst_nack", 32'(rif.nack_seen), 32'(0));
        check("rst_sda", 32'(sda), 32'(1));
        reset = 1'b0;
        repeat (10) @(posedge sys_clock);
        #1;

        dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
        do_write(SLV, 8'h10, 2, 1'b1);
        flush_checks("wr2");

        do_write(SLV, 8'h20, 0, 1'b0);
        do_read(2);
        flush_checks("rd2");

        dbuf[0] = 8'h00;
        do_write(7'h51, 8'h00, 1, 1'b1);
        flush_checks("wrong_addr");

        dbuf[0] = 8'h01; dbuf[1] = 8'h02;
        do_write(SLV, 8'hFF, 2, 1'b1);
        flush_checks("wrap");

        // 2-cycle SDA dip while SCL high must not open a transaction.
        m_low = 1'b1;
        repeat (2) @(posedge sys_clock);
        #1 m_low = 1'b0;
        wait_q();
        check("glitch_busy", 32'(rif.busy), 32'(0));
        scl = 1'b0;
        wr_byte({SLV, 1'b0}, ack);
        check("glitch_no_ack", 32'(ack), 32'(0));
        i2c_stop();
        flush_checks("glitch");

        for (int t = 0; t < 6; t++) begin
            op = int'($urandom_range(0, 2));
            n  = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) dbuf[k] = 8'($urandom);
            a7 = ($urandom_range(0, 4) == 0) ? (SLV ^ 7'(1 << $urandom_range(0, 6))) : SLV;
            case (op)
                0: do_write(a7, 8'($urandom), n, 1'b1);
                1: begin
                    do_write(SLV, 8'($urandom), 0, 1'b0);
                    do_read(n);
                end
                default: do_read(n);
            endcase
            flush_checks("rand");
        end

        // Reset while the slave is holding SDA low for the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) put_bit(((8'(SLV) << 1) >> i) & 8'h01 ? 1'b1 : 1'b0, s);
        wait_q(); m_low = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q();
        check("ack_driven", 32'(sda), 32'(0));
        reset = 1'b1;
        #1;
        check("rst_mid_sda", 32'(sda), 32'(1));
        @(negedge sys_clock);
        check("rst_mid_busy", 32'(rif.busy), 32'(0));
        check("rst_mid_reg_addr", 32'(rif.reg_addr), 32'(0));
        repeat (3) @(posedge sys_clock);
        #1 reset = 1'b0;
        exp_ptr = 8'h00;
        wr_seen.delete(); rd_seen.delete();
        repeat (10) @(posedge sys_clock);
        #1;
        do_read(1);
        flush_checks("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (7-bit addressing, EEPROM-like register protocol) for on-board I2C peripherals emulated in the FPGA.
- Exposes a byte-wide register-file port to the SoC side.
- Decodes START/STOP, matches its address, and treats the first written byte as a subaddress pointer.
- Writes subsequent bytes through the pointer and serves reads from the pointer; the pointer auto-increments.
- No clock stretching; not multi-master aware.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit I2C address this block responds to.
- FREQ, 50, sys_clock frequency in MHz; sets SDA hold delay.

Ports:
- sys_clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- SDA  inout  1  I2C data; open drain: drives 0 or Z only
- SCL  in  1  I2C clock; input only, never driven
- reg_addr  out  8  current subaddress pointer
- reg_wdata  out  8  write data, valid while reg_wr=1
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read request for reg_addr
- reg_rdata  in  8  read data; must be valid the cycle after reg_rd
- busy  out  1  1 from address match until STOP/START ends the transaction
- nack_seen  out  1  sticky; set when the master NACKs a read byte, cleared at next address match

Behaviour:
- Reset (async, active-high) -> all outputs low, reg_addr=0, SDA released (Z), state IDLE. Reset mid-transfer releases SDA in the same edge.
- Input conditioning: SDA and SCL each pass a 2-flop synchroniser, then a 4-deep shift register. The filtered value changes only when all 4 samples agree. All edges and conditions below use filtered values.
  - START: filtered SDA 1->0 while SCL=1.
  - STOP: filtered SDA 0->1 while SCL=1.
  - START or STOP is recognised in every state, including repeated START, and takes priority over bit processing.
- Bit sampling: data is shifted in MSB first on filtered SCL rising edge.
- Own-drive changes: any change to our SDA drive is made T_HOLD=(FREQ>>2)+1 cycles after a filtered SCL falling edge. During SCL high, our SDA drive never changes.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: 8 bits = {addr[6:0], rw}. After the 8th rising edge:
    - match -> ADDR_ACK; set busy; clear nack_seen.
    - mismatch -> WAIT (SDA released, ignore bits until START/STOP).
  - ADDR_ACK: drive SDA=0 after the falling edge following bit 8; release after the next falling edge.
    - rw=0 -> SUB.
    - rw=1 -> pulse reg_rd at the ACK falling edge, latch reg_rdata the next cycle, -> RDATA.
  - SUB: receive 8 bits, load into reg_addr -> SUB_ACK (ACK as above) -> WDATA.
  - WDATA: receive 8 bits, then:
    - reg_wdata <= byte.
    - One-cycle reg_wr pulse on the cycle after the 8th rising edge, with reg_addr unchanged during the pulse.
    - reg_addr increments one cycle after reg_wr; 8'hFF wraps to 8'h00.
    - -> WDATA_ACK (ACK) -> WDATA.
  - RDATA: drive shift-register MSB after each falling edge, 8 bits. After the 8th falling edge release SDA -> RDATA_ACK.
  - RDATA_ACK: sample SDA on the rising edge.
    - 0 (ACK): reg_addr++ (wrap) and, at the following falling edge, pulse reg_rd and reload -> RDATA.
    - 1 (NACK): set nack_seen -> WAIT.
  - WAIT: SDA released.
- Transaction end:
  - STOP in any state -> IDLE, busy=0, SDA released.
  - START in any state -> ADDR; busy kept until the address resolves, then set per the match result.
- reg_addr persists across transactions. A read without a prior subaddress write uses the persisted pointer (EEPROM current-address read).
- Minimum sys_clock/SCL ratio: FREQ=50 meets 400 kHz.

Test Plan:
- Reset while SDA is being driven for ACK -> SDA=Z the same cycle; busy=0; reg_addr=0.
- Write {0x50,W}, 0x10, 0xAA, 0xBB, STOP:
  - ACK on all 4 bytes.
  - reg_wr pulses twice: reg_addr=0x10/wdata=0xAA, then reg_addr=0x11/wdata=0xBB.
  - Final reg_addr=0x12; busy falls at STOP.
- Write {0x50,W}, 0x20, repeated START, {0x50,R}, read 2 bytes with ACK then NACK, STOP. With reg_rdata = addr^0x5A:
  - SDA bytes = 0x7A, 0x7B.
  - reg_rd pulses for 0x20 and 0x21; nack_seen=1.
- Address {0x51,W}, then 0x00 -> no ACK (SDA high in the 9th clock); no reg_wr; busy stays 0; STOP -> IDLE.
- Pointer wrap: write sub 0xFF, data 0x01, 0x02 -> writes land at 0xFF then 0x00; final reg_addr=0x01.
- Glitch: 2-cycle SDA low pulse while SCL high in IDLE -> no START detected; busy stays 0; a following legal transaction is unaffected.
